// File: rtl/edl_line_detect_pio_if.sv
// Avalon-MM slave bus bundle for the line-detect PIO.
// The master side drives address/strobes; the slave returns registered read data.
interface edl_line_detect_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/edl_line_detect_pio.sv
// Line-sensor input PIO: per-line synchroniser, debounce filter, edge capture
// with selectable edge mode, interrupt mask and level interrupt on Avalon-MM.
module edl_line_detect_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    edl_line_detect_pio_if.slave    bus,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] filtered_r;
    logic [WIDTH-1:0] filtered_d_r;
    logic [CNT_W-1:0] cnt_r [WIDTH];
    logic [1:0]       edge_mode_r;
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] edge_capture_r;
    logic [31:0]      readdata_r;

    logic [WIDTH-1:0] filt_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] hit_s;
    logic [WIDTH-1:0] w1c_s;
    logic [WIDTH-1:0] capture_nxt_s;
    logic [31:0]      rd_mux_s;
    logic             wr_s;
    logic             unused_s;

    assign wr_s     = bus.chipselect & ~bus.write_n;
    assign unused_s = &{1'b0, bus.writedata};

    // Two-flop synchroniser per input line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state: a line must disagree for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        filt_nxt_s = filtered_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync2_r[i] == filtered_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_MAX) begin
                filt_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]  = CNT_ZERO;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Filtered value, its one-cycle delay and the per-line debounce counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filtered_r   <= {WIDTH{1'b0}};
            filtered_d_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            filtered_r   <= filt_nxt_s;
            filtered_d_r <= filtered_r;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Edge selection and capture update; a new hit overrides a same-cycle W1C.
    always_comb begin
        rise_s = filtered_r & ~filtered_d_r;
        fall_s = ~filtered_r & filtered_d_r;
        case (edge_mode_r)
            2'd0:    hit_s = rise_s;
            2'd1:    hit_s = fall_s;
            2'd2:    hit_s = rise_s | fall_s;
            2'd3:    hit_s = rise_s | fall_s;
            default: hit_s = {WIDTH{1'b0}};
        endcase
        if (wr_s && (bus.address == 2'd3)) begin
            w1c_s = bus.writedata[WIDTH-1:0];
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
        capture_nxt_s = (edge_capture_r & ~w1c_s) | hit_s;
    end

    // Software-visible control registers and edge capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_mode_r    <= 2'd0;
            irq_mask_r     <= {WIDTH{1'b0}};
            edge_capture_r <= {WIDTH{1'b0}};
        end else begin
            if (wr_s && (bus.address == 2'd1)) begin
                edge_mode_r <= bus.writedata[1:0];
            end
            if (wr_s && (bus.address == 2'd2)) begin
                irq_mask_r <= bus.writedata[WIDTH-1:0];
            end
            edge_capture_r <= capture_nxt_s;
        end
    end

    // Read mux; sampled every cycle whether or not the slave is selected.
    always_comb begin
        case (bus.address)
            2'd0:    rd_mux_s = 32'(filtered_r);
            2'd1:    rd_mux_s = {30'd0, edge_mode_r};
            2'd2:    rd_mux_s = 32'(irq_mask_r);
            2'd3:    rd_mux_s = 32'(edge_capture_r);
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, one cycle after the address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_mux_s;
        end
    end

    assign bus.readdata = readdata_r;
    // Driven only from flops, so the level cannot glitch on bus activity.
    assign irq = |(edge_capture_r & irq_mask_r);

endmodule

// File: tb/tb_edl_line_detect_pio.sv
// Scoreboard bench for edl_line_detect_pio: a history-window reference model predicts
// every read response; a negedge monitor pops and compares. Directed spec cases plus random traffic.
module tb_edl_line_detect_pio;
    localparam int W = 4;
    localparam int D = 4;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '0;
    logic         irq;
    logic         rd_req = 1'b0;

    int errors = 0;
    int checks = 0;

    edl_line_detect_pio_if bif ();

    edl_line_detect_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // filtered[i] flips when the synchronised input (in_port two samples late) has
    // shown the opposite value for the last D clock edges.
    exp_t         exp_q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_filt, m_filt_d, m_mask, m_cap;
    logic [1:0]   m_mode;
    logic         mon_valid = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        logic [31:0]  rdv;
        logic [W-1:0] hit, w1c, nf, ncap;
        logic         allopp;
        exp_t         e;
        if (!reset_n) begin
            m_filt = '0; m_filt_d = '0; m_mask = '0; m_cap = '0; m_mode = 2'd0;
            mon_valid = 1'b0;
            exp_q.delete();
            hist.delete();
            for (int k = 0; k < D + 2; k++) hist.push_back('0);
        end else begin
            case (bif.address)
                2'd0: rdv = 32'(m_filt);
                2'd1: rdv = 32'(m_mode);
                2'd2: rdv = 32'(m_mask);
                default: rdv = 32'(m_cap);
            endcase
            case (m_mode)
                2'd0: hit = m_filt & ~m_filt_d;
                2'd1: hit = ~m_filt & m_filt_d;
                default: hit = m_filt ^ m_filt_d;
            endcase
            w1c = (bif.chipselect && !bif.write_n && bif.address == 2'd3) ? bif.writedata[W-1:0] : '0;
            ncap = (m_cap & ~w1c) | hit;
            if (bif.chipselect && !bif.write_n && bif.address == 2'd1) m_mode = bif.writedata[1:0];
            if (bif.chipselect && !bif.write_n && bif.address == 2'd2) m_mask = bif.writedata[W-1:0];
            nf = m_filt;
            for (int b = 0; b < W; b++) begin
                allopp = 1'b1;
                for (int j = 1; j <= D; j++) if (hist[j][b] == m_filt[b]) allopp = 1'b0;
                if (allopp) nf[b] = ~m_filt[b];
            end
            m_filt_d = m_filt;
            m_filt = nf;
            m_cap = ncap;
            hist.push_front(in_port);
            void'(hist.pop_back());
            if (rd_req) begin
                e.rd = rdv;
                e.irq = |(m_cap & m_mask);
                exp_q.push_back(e);
            end
            mon_valid = rd_req;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (mon_valid) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb readdata", bif.readdata, e.rd);
                chk("sb irq", 32'(irq), 32'(e.irq));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bif.address = a; bif.chipselect = 1'b1; bif.write_n = 1'b0; bif.writedata = d; rd_req = 1'b0;
        @(negedge clk);
        bif.chipselect = 1'b0; bif.write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bif.address = a; bif.chipselect = 1'b0; bif.write_n = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        d = bif.readdata;
    endtask

    task automatic settle_clear();
        in_port = '0;
        idle(10);
        wr(2'd3, 32'hF);
    endtask

    initial begin
        logic [31:0] d;
        bif.address = 2'd0; bif.chipselect = 1'b0; bif.write_n = 1'b1; bif.writedata = 32'd0;
        idle(2);
        chk("reset readdata", bif.readdata, 32'd0);
        chk("reset irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // reset while a debounce count is in progress
        in_port = 4'b0001;
        idle(3);
        reset_n = 1'b0;
        idle(1);
        chk("mid reset readdata", bif.readdata, 32'd0);
        chk("mid reset irq", 32'(irq), 32'd0);
        idle(1);
        reset_n = 1'b1;
        rd(2'd1, d); chk("post reset EDGE_MODE", d, 32'd0);
        rd(2'd2, d); chk("post reset IRQ_MASK", d, 32'd0);
        rd(2'd3, d); chk("post reset EDGE_CAPTURE", d, 32'd0);
        rd(2'd0, d); chk("post reset DATA early", d, 32'd0);
        idle(6);
        rd(2'd0, d); chk("post reset DATA restart", d, 32'd1);
        rd(2'd3, d); chk("held-high rise after reset", d, 32'd1);
        settle_clear();
        rd(2'd3, d); chk("capture cleared", d, 32'd0);

        // debounce latency: 2 sync + D filter cycles, then one read cycle
        in_port = 4'b0001;
        for (int i = 1; i <= 7; i++) begin
            rd(2'd0, d);
            chk("debounce latency", d, (i == 7) ? 32'd1 : 32'd0);
        end
        settle_clear();
        in_port = 4'b0010;
        idle(3);
        in_port = 4'b0000;
        idle(8);
        rd(2'd0, d); chk("glitch DATA", d, 32'd0);
        rd(2'd3, d); chk("glitch capture", d, 32'd0);

        // edge modes on bit2
        for (int m = 0; m < 3; m++) begin
            wr(2'd1, 32'(m));
            in_port = 4'b0100;
            idle(10);
            rd(2'd3, d); chk("mode after rise", d, (m == 1) ? 32'd0 : 32'd4);
            if (m == 2) wr(2'd3, 32'h4);
            in_port = 4'b0000;
            idle(10);
            rd(2'd3, d); chk("mode after fall", d, 32'd4);
            wr(2'd3, 32'hF);
        end

        // irq mask and W1C
        wr(2'd1, 32'd0);
        wr(2'd2, 32'h2);
        in_port = 4'b1010;
        idle(10);
        rd(2'd3, d); chk("irq capture", d, 32'hA);
        chk("irq asserted", 32'(irq), 32'd1);
        wr(2'd3, 32'h2);
        chk("irq after W1C", 32'(irq), 32'd0);
        rd(2'd3, d); chk("capture after W1C", d, 32'h8);
        wr(2'd2, 32'h8);
        chk("irq mask 0x8", 32'(irq), 32'd1);
        wr(2'd2, 32'h0);
        chk("irq mask cleared", 32'(irq), 32'd0);
        settle_clear();

        // W1C on the very cycle the bit0 rise is captured
        in_port = 4'b0001;
        repeat (6) @(negedge clk);
        wr(2'd3, 32'h1);
        rd(2'd3, d); chk("set beats W1C", 32'(d[0]), 32'd1);

        // bus edge cases
        wr(2'd0, 32'hF);
        rd(2'd0, d); chk("DATA read-only", d, 32'd1);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, d); chk("IRQ_MASK width", d, 32'hF);
        wr(2'd2, 32'd0);
        settle_clear();

        // random traffic, every cycle read back through the scoreboard
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
            bif.address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                bif.address = 2'($urandom_range(1, 3));
                bif.chipselect = 1'b1; bif.write_n = 1'b0; bif.writedata = $urandom;
            end else begin
                bif.chipselect = ($urandom_range(0, 1) == 1); bif.write_n = 1'b1;
            end
            rd_req = 1'b1;
            @(negedge clk);
        end
        rd_req = 1'b0; bif.chipselect = 1'b0; bif.write_n = 1'b1;
        idle(3);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
